// File: rtl/packet_uart_tx.sv
// packet_uart_tx: sends a latched packet as back-to-back 8N1 UART frames, byte 0 first, then pulses clear
module packet_uart_tx #(
  parameter int PACKET_SIZE = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PACKET_SIZE-1:0] packet,
  input  logic                   send,
  output logic                   tx,
  output logic                   busy,
  output logic                   clear
);
  localparam int NBYTES = PACKET_SIZE / 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, WAIT} state_t;
  state_t state;
  logic [CW-1:0] baud;
  logic [2:0] bit_idx;
  logic [BW-1:0] byte_idx;
  logic [PACKET_SIZE-1:0] sh;
  logic tick;
  assign tick = baud == CW'(CLKS_PER_BIT - 1);
  // outputs are registered from the current state, so they trail the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      clear <= 1'b0;
    end else begin
      tx <= state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
      busy <= state != IDLE;
      clear <= state == DONE;
      baud <= (state inside {START, DATA, STOP}) && !tick ? baud + 1'b1 : '0;
      case (state)
        IDLE: if (send) begin
          sh <= packet;
          byte_idx <= '0;
          state <= START;
        end
        START: if (tick) begin
          bit_idx <= '0;
          state <= DATA;
        end
        // the whole register shifts, so the next byte is already aligned at bit 0
        DATA: if (tick) begin
          sh <= sh >> 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (tick) begin
          if (byte_idx == BW'(NBYTES - 1)) state <= DONE;
          else begin
            byte_idx <= byte_idx + 1'b1;
            state <= START;
          end
        end
        DONE: state <= WAIT;
        WAIT: if (!send) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_packet_uart_tx.sv
// tb_packet_uart_tx: directed checks of packet_uart_tx in a 16-bit/4-clk and an 8-bit/2-clk configuration
module tb_packet_uart_tx;
  logic clk = 1'b0;
  logic rst, send, tx, busy, clear;
  logic [15:0] packet;
  logic rst2, send2, tx2, busy2, clear2;
  logic [7:0] packet2;
  int checks = 0;
  int errors = 0;
  int n_clr1 = 0;
  int n_clr2 = 0;

  always #5 clk = ~clk;

  packet_uart_tx #(.PACKET_SIZE(16), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .packet(packet), .send(send), .tx(tx), .busy(busy), .clear(clear)
  );
  packet_uart_tx #(.PACKET_SIZE(8), .CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst2), .packet(packet2), .send(send2), .tx(tx2), .busy(busy2), .clear(clear2)
  );

  always @(negedge clk) begin
    if (clear) n_clr1 = n_clr1 + 1;
    if (clear2) n_clr2 = n_clr2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // cycle i after tx falls: start bit, 8 data bits LSB first, stop bit, each c cycles
  function automatic logic exp_bit(input logic [15:0] d, input int i, input int c);
    int f = i / (10 * c);
    int p = (i / c) % 10;
    return p == 0 ? 1'b0 : p == 9 ? 1'b1 : d[8 * f + p - 1];
  endfunction

  task automatic frame16(input logic [15:0] exp, input int mod_at, input int abort_at);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); @(negedge clk);
      check("tx16", tx, exp_bit(exp, i, 4));
      check("busy16", busy, 1);
      check("clr16", clear, 0);
      if (i == mod_at) packet = 16'hFFFF;
      if (i == abort_at) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  task automatic frame8(input logic [7:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      check("tx8", tx2, exp_bit({8'h00, exp}, i, 2));
      check("busy8", busy2, 1);
      check("clr8", clear2, 0);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; send = 1'b1; packet = 16'hA55A; send2 = 1'b0; packet2 = 8'h00;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_clr", clear, 0);
    end
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rel_tx", tx, 1);
    check("rel_busy", busy, 0);
    frame16(16'hA55A, 20, -1);
    @(posedge clk); @(negedge clk);
    check("clr_pulse", clear, 1);
    check("clr_tx", tx, 1);
    repeat (200) begin
      @(posedge clk); @(negedge clk);
      check("stuck_clr", clear, 0);
      check("stuck_busy", busy, 1);
      check("stuck_tx", tx, 1);
    end
    send = 1'b0;
    @(posedge clk); @(negedge clk);
    check("wait_busy", busy, 1);
    @(posedge clk); @(negedge clk);
    check("idle_busy", busy, 0);
    packet = 16'hA55A; send = 1'b1;
    @(posedge clk); #1 send = 1'b0;
    frame16(16'hA55A, -1, 50);
    @(posedge clk); @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    repeat (100) begin
      @(posedge clk); @(negedge clk);
      check("abort_clr", clear, 0);
      check("abort_idle_tx", tx, 1);
    end
    packet = 16'h00FF; send = 1'b1;
    @(posedge clk); #1 send = 1'b0;
    frame16(16'h00FF, -1, -1);
    @(posedge clk); @(negedge clk);
    check("clr_pulse2", clear, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_busy2", busy, 0);
    packet2 = 8'h3C; send2 = 1'b1;
    @(posedge clk);
    frame8(8'h3C);
    @(posedge clk); @(negedge clk);
    check("b2b_clr1", clear2, 1);
    send2 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_wait_busy", busy2, 1);
    check("b2b_gap_clr", clear2, 0);
    check("b2b_gap_tx", tx2, 1);
    @(posedge clk); @(negedge clk);
    check("b2b_idle_busy", busy2, 0);
    check("b2b_idle_tx", tx2, 1);
    packet2 = 8'h81; send2 = 1'b1;
    @(posedge clk);
    frame8(8'h81);
    @(posedge clk); @(negedge clk);
    check("b2b_clr2", clear2, 1);
    send2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b2b_end_busy", busy2, 0);
    check("n_clear8", n_clr2, 2);
    check("n_clear16", n_clr1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
